// File: rtl/multi_channel_bus_synchronizer_pkg.sv
// rtl/multi_channel_bus_synchronizer_pkg.sv - shared constants and helpers for the bus synchronizer
package multi_channel_bus_synchronizer_pkg;

    localparam int DEFAULT_STAGE_COUNT   = 2;
    localparam int DEFAULT_BUS_WIDTH     = 4;
    localparam int DEFAULT_CHANNEL_COUNT = 2;
    localparam int DEFAULT_STABLE_CYCLES = 2;
    localparam int DEFAULT_GRAY_CHECK    = 1;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Each binary bit is the xor of its gray bit and every gray bit above it.
    // Unused upper bits are zero, so the result is exact for any narrower bus.
    function automatic logic [31:0] gray_to_binary(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Number of set bits; applied to a xor it gives the hamming distance.
    function automatic int popcount(input logic [31:0] value);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + int'(value[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/multi_channel_bus_synchronizer_channel.sv
// rtl/multi_channel_bus_synchronizer_channel.sv - one channel: sync chain, stability filter, outputs, gray check
module bus_synchronizer_channel
    import multi_channel_bus_synchronizer_pkg::*;
#(
    parameter int STAGE_COUNT   = DEFAULT_STAGE_COUNT,
    parameter int BUS_WIDTH     = DEFAULT_BUS_WIDTH,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int GRAY_CHECK    = DEFAULT_GRAY_CHECK
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] async_data,
    input  logic                 error_clear,
    output logic [BUS_WIDTH-1:0] sync_data,
    output logic [BUS_WIDTH-1:0] bin_data,
    output logic                 changed,
    output logic                 gray_error
);

    localparam int              RUN_W   = clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic [BUS_WIDTH-1:0] chain [STAGE_COUNT];
    logic [BUS_WIDTH-1:0] held;
    logic [BUS_WIDTH-1:0] last;
    logic [RUN_W-1:0]     run_cnt;
    logic [RUN_W-1:0]     run_next;
    logic                 accept;
    logic                 multi_bit;

    // Metastability chain: stage 0 samples the foreign bus, later stages settle it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGE_COUNT; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= async_data;
            for (int i = 1; i < STAGE_COUNT; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    // Run length of identical chain outputs and the resulting accept decision.
    always_comb begin
        last = chain[STAGE_COUNT-1];
        if (last == held) begin
            run_next = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + RUN_ONE;
        end else begin
            run_next = RUN_ONE;
        end
        accept    = (run_next == RUN_MAX) && (last != sync_data);
        multi_bit = popcount(32'(last ^ sync_data)) > 1;
    end

    // Filter state and accepted outputs; changed is a single-cycle pulse per accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            held      <= '0;
            run_cnt   <= '0;
            sync_data <= '0;
            bin_data  <= '0;
            changed   <= 1'b0;
        end else begin
            held    <= last;
            run_cnt <= run_next;
            changed <= accept;
            if (accept) begin
                sync_data <= last;
                bin_data  <= BUS_WIDTH'(gray_to_binary(32'(last)));
            end
        end
    end

    // Sticky multi-bit flag; a new offence beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            gray_error <= 1'b0;
        end else if ((GRAY_CHECK != 0) && accept && multi_bit) begin
            gray_error <= 1'b1;
        end else if (error_clear) begin
            gray_error <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_channel_bus_synchronizer.sv
// rtl/multi_channel_bus_synchronizer.sv - top: slices buses and instantiates one synchronizer per channel
module multi_channel_bus_synchronizer
    import multi_channel_bus_synchronizer_pkg::*;
#(
    parameter int STAGE_COUNT   = DEFAULT_STAGE_COUNT,
    parameter int BUS_WIDTH     = DEFAULT_BUS_WIDTH,
    parameter int CHANNEL_COUNT = DEFAULT_CHANNEL_COUNT,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int GRAY_CHECK    = DEFAULT_GRAY_CHECK
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [CHANNEL_COUNT*BUS_WIDTH-1:0] asynchronous_data,
    input  logic [CHANNEL_COUNT-1:0]           error_clear,
    output logic [CHANNEL_COUNT*BUS_WIDTH-1:0] synchronous_data,
    output logic [CHANNEL_COUNT*BUS_WIDTH-1:0] binary_data,
    output logic [CHANNEL_COUNT-1:0]           data_changed,
    output logic [CHANNEL_COUNT-1:0]           gray_error
);

    // Channels share nothing but the clock and reset.
    for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_channel
        bus_synchronizer_channel #(
            .STAGE_COUNT  (STAGE_COUNT),
            .BUS_WIDTH    (BUS_WIDTH),
            .STABLE_CYCLES(STABLE_CYCLES),
            .GRAY_CHECK   (GRAY_CHECK)
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .async_data (asynchronous_data[c*BUS_WIDTH +: BUS_WIDTH]),
            .error_clear(error_clear[c]),
            .sync_data  (synchronous_data[c*BUS_WIDTH +: BUS_WIDTH]),
            .bin_data   (binary_data[c*BUS_WIDTH +: BUS_WIDTH]),
            .changed    (data_changed[c]),
            .gray_error (gray_error[c])
        );
    end

endmodule

// File: tb/tb_multi_channel_bus_synchronizer.sv
// tb/tb_multi_channel_bus_synchronizer.sv - self-checking bench for multi_channel_bus_synchronizer
module tb_multi_channel_bus_synchronizer;

    localparam int S  = 2;
    localparam int ST = 2;
    localparam int W  = 4;
    localparam int C  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [C*W-1:0] adata;
    logic [C-1:0]   eclr;
    logic [C*W-1:0] sync_a, bin_a, sync_b, bin_b;
    logic [C-1:0]   chg_a, err_a, chg_b, err_b;

    multi_channel_bus_synchronizer #(
        .STAGE_COUNT(S), .BUS_WIDTH(W), .CHANNEL_COUNT(C), .STABLE_CYCLES(ST), .GRAY_CHECK(1)
    ) dut_a (
        .clk(clk), .reset(reset), .asynchronous_data(adata), .error_clear(eclr),
        .synchronous_data(sync_a), .binary_data(bin_a), .data_changed(chg_a), .gray_error(err_a)
    );

    multi_channel_bus_synchronizer #(
        .STAGE_COUNT(S), .BUS_WIDTH(W), .CHANNEL_COUNT(C), .STABLE_CYCLES(ST), .GRAY_CHECK(0)
    ) dut_b (
        .clk(clk), .reset(reset), .asynchronous_data(adata), .error_clear(eclr),
        .synchronous_data(sync_b), .binary_data(bin_b), .data_changed(chg_b), .gray_error(err_b)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;

    // Reference model: history of input values seen at each edge.
    logic [W-1:0] hist [C][$];
    logic [W-1:0] m_sync [C];
    logic [W-1:0] m_bin  [C];
    logic         m_chg  [C];
    logic         m_err  [C];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Binary index whose gray code equals g.
    function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
        for (int n = 0; n < (1 << W); n++) begin
            if (W'(n ^ (n >> 1)) == g) return W'(n);
        end
        return '0;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < C; c++) begin
            hist[c].delete();
            for (int i = 0; i < S + ST; i++) hist[c].push_back('0);
            m_sync[c] = '0;
            m_bin[c]  = '0;
            m_chg[c]  = 1'b0;
            m_err[c]  = 1'b0;
        end
    endfunction

    // Chain output at an edge is the input from S edges earlier; accept when the
    // last ST such samples agree and differ from the held output.
    function automatic void model_edge();
        if (reset) begin
            model_reset();
            return;
        end
        for (int c = 0; c < C; c++) begin
            logic [W-1:0] v;
            logic         steady;
            int           n;
            hist[c].push_back(adata[c*W +: W]);
            void'(hist[c].pop_front());
            n = hist[c].size();
            v = hist[c][n-1-S];
            steady = 1'b1;
            for (int j = 0; j < ST; j++) begin
                if (hist[c][n-1-S-j] != v) steady = 1'b0;
            end
            m_chg[c] = steady && (v != m_sync[c]);
            if (m_chg[c]) begin
                if ($countones(v ^ m_sync[c]) > 1) m_err[c] = 1'b1;
                else if (eclr[c]) m_err[c] = 1'b0;
                m_sync[c] = v;
                m_bin[c]  = ref_bin(v);
            end else if (eclr[c]) begin
                m_err[c] = 1'b0;
            end
        end
    endfunction

    task automatic step();
        logic [C*W-1:0] es, eb;
        logic [C-1:0]   ec, ee;
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < C; c++) begin
            es[c*W +: W] = m_sync[c];
            eb[c*W +: W] = m_bin[c];
            ec[c] = m_chg[c];
            ee[c] = m_err[c];
        end
        check("sync_data", 32'(sync_a), 32'(es));
        check("binary_data", 32'(bin_a), 32'(eb));
        check("data_changed", 32'(chg_a), 32'(ec));
        check("gray_error", 32'(err_a), 32'(ee));
        check("nocheck_sync", 32'(sync_b), 32'(es));
        check("nocheck_gray_error", 32'(err_b), 32'(0));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int pulses;
        logic [W-1:0] cur [C];
        reset = 1'b1;
        adata = 8'hFF;
        eclr  = '0;
        model_reset();

        // Reset holds everything at zero despite an all-ones input.
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_zero", 32'({sync_a, bin_a, chg_a, err_a}), 32'(0));
        end
        reset = 1'b0;
        steps(3);
        check("ff_not_yet", 32'(sync_a), 32'(0));
        step();
        check("ff_sync", 32'(sync_a), 32'hFF);
        check("ff_bin", 32'(bin_a), 32'hAA);
        check("ff_pulse", 32'(chg_a), 32'h3);
        check("ff_err_check_on", 32'(err_a), 32'h3);
        check("ff_err_check_off", 32'(err_b), 32'h0);
        step();
        check("ff_pulse_end", 32'(chg_a), 32'h0);

        // Clean start, then a single-bit step on ch0.
        reset = 1'b1; adata = 8'h00; steps(2);
        reset = 1'b0; steps(4);
        adata = 8'h01; steps(3);
        check("ch0_pre", 32'(sync_a), 32'h00);
        step();
        check("ch0_0001", 32'(sync_a), 32'h01);
        check("ch0_bin", 32'(bin_a), 32'h01);
        check("ch0_pulse", 32'(chg_a), 32'h1);
        step();
        check("ch0_pulse_once", 32'(chg_a), 32'h0);
        steps(2);

        // One-cycle glitch on ch1 is filtered.
        adata = 8'h31; step();
        adata = 8'h01; steps(6);
        check("ch1_glitch", 32'(sync_a), 32'h01);

        // Two-bit jump on ch0 flags gray_error; clear; then set beats clear.
        adata = 8'h07; steps(6);
        check("jump_err", 32'(err_a), 32'h1);
        check("jump_bin", 32'(bin_a[3:0]), 32'h5);
        eclr = 2'b01; step();
        eclr = 2'b00;
        check("err_cleared", 32'(err_a), 32'h0);
        adata = 8'h04; steps(3);
        eclr = 2'b01; step();
        eclr = 2'b00;
        check("set_beats_clear", 32'(err_a), 32'h1);
        steps(2);

        // Full gray cycle on ch0 with wrap back to 0000.
        reset = 1'b1; adata = 8'h00; step();
        reset = 1'b0; steps(4);
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            adata[3:0] = W'((k % 16) ^ ((k % 16) >> 1));
            for (int h = 0; h < 3; h++) begin
                step();
                pulses += int'(chg_a[0]);
            end
        end
        for (int h = 0; h < 4; h++) begin
            step();
            pulses += int'(chg_a[0]);
        end
        check("gray_pulses", 32'(pulses), 32'd16);
        check("gray_no_err", 32'(err_a), 32'h0);

        // Reset mid-stream at ch0=0110 and reacquire.
        adata = 8'h06; steps(6);
        check("pre_reset", 32'(sync_a[3:0]), 32'h6);
        reset = 1'b1; step();
        check("mid_reset_zero", 32'({sync_a, bin_a, chg_a, err_a}), 32'(0));
        reset = 1'b0; steps(3);
        check("reacq_wait", 32'(sync_a), 32'h0);
        step();
        check("reacq", 32'(sync_a[3:0]), 32'h6);
        check("reacq_bin", 32'(bin_a[3:0]), 32'h4);

        // Randomized gray walks, occasional jumps, glitches and clears.
        for (int c = 0; c < C; c++) cur[c] = adata[c*W +: W];
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < C; c++) begin
                int r;
                r = int'($urandom_range(99, 0));
                if (r < 25) cur[c] = cur[c] ^ W'(1 << $urandom_range(W-1, 0));
                else if (r < 30) cur[c] = W'($urandom);
                adata[c*W +: W] = cur[c];
            end
            eclr  = ($urandom_range(9, 0) == 0) ? C'($urandom) : '0;
            reset = ($urandom_range(99, 0) == 0);
            step();
        end
        reset = 1'b0; eclr = '0;
        steps(6);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
